// File: rtl/custom_axi_ip_axil_regs.sv
// custom_axi_ip_axil_regs: AXI4-Lite register file driving the custom_axi_ip core; define CUSTOM_AXI_IP_IRQ_EN to add IER and irq_o
module custom_axi_ip_axil_regs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [3:0]            s_wstrb_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic                  enable_in_o,
  input  logic [DATA_WIDTH-1:0] dout_i,
  input  logic [1:0]            enable_out_i,
  input  logic [1:0]            status_i
`ifdef CUSTOM_AXI_IP_IRQ_EN
  ,
  output logic                  irq_o
`endif
);
  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_DIN = 3'd1;
  localparam logic [2:0] A_DOUT = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;
  localparam logic [2:0] A_IER = 3'd4;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [2:0] aw_idx, rd_idx;
  logic aw_held, w_held;
  logic [31:0] wdata_q, din_next, dout_q, rd_mux;
  logic [3:0] wstrb_q;
  logic wr_commit, wr_mapped, rd_mapped, start_evt, clr_ack, clr_be;
  logic ack, busyerr;
  logic [1:0] ier;
  logic unused_ok;
  assign unused_ok = ^{enable_out_i[1], s_awaddr_i[1:0], s_araddr_i[1:0]};
`ifdef CUSTOM_AXI_IP_IRQ_EN
  localparam logic [2:0] A_LAST = A_IER;
`else
  localparam logic [2:0] A_LAST = A_STAT;
  assign ier = 2'b00;
`endif
  // commit strobes, merged DIN value and read-data selection
  always_comb begin
    rd_idx = s_araddr_i[4:2];
    wr_commit = (w_state == W_IDLE) && aw_held && w_held;
    wr_mapped = aw_idx <= A_LAST;
    rd_mapped = rd_idx <= A_LAST;
    start_evt = wr_commit && aw_idx == A_CTRL && wdata_q[0];
    clr_ack = wr_commit && aw_idx == A_STAT && wdata_q[2];
    clr_be = wr_commit && aw_idx == A_STAT && wdata_q[3];
    din_next = din_o;
    for (int i = 0; i < 4; i++) din_next[8*i+:8] = wstrb_q[i] ? wdata_q[8*i+:8] : din_o[8*i+:8];
    rd_mux = rd_idx == A_DIN  ? din_o :
             rd_idx == A_DOUT ? dout_q :
             rd_idx == A_STAT ? {28'd0, busyerr, ack, status_i} :
             rd_idx == A_IER && rd_mapped ? {30'd0, ier} : 32'd0;
  end
  // write channel: capture AW and W independently, commit once both are held, then hold B
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      s_awready_o <= 1'b0;
      s_wready_o <= 1'b0;
      s_bvalid_o <= 1'b0;
      s_bresp_o <= OKAY;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= 3'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (w_state == W_IDLE) begin
      if (s_awready_o && s_awvalid_i) begin
        aw_held <= 1'b1;
        aw_idx <= s_awaddr_i[4:2];
      end
      if (s_wready_o && s_wvalid_i) begin
        w_held <= 1'b1;
        wdata_q <= s_wdata_i;
        wstrb_q <= s_wstrb_i;
      end
      s_awready_o <= !aw_held && !(s_awready_o && s_awvalid_i);
      s_wready_o <= !w_held && !(s_wready_o && s_wvalid_i);
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_bvalid_o <= 1'b1;
        s_bresp_o <= wr_mapped ? OKAY : SLVERR;
        w_state <= W_RESP;
      end
    end else if (s_bready_i) begin
      s_bvalid_o <= 1'b0;
      s_awready_o <= 1'b1;
      s_wready_o <= 1'b1;
      w_state <= W_IDLE;
    end
  end
  // read channel: register data and response on the AR handshake, hold until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      s_arready_o <= 1'b0;
      s_rvalid_o <= 1'b0;
      s_rdata_o <= 32'd0;
      s_rresp_o <= OKAY;
    end else if (r_state == R_IDLE) begin
      s_arready_o <= 1'b1;
      if (s_arready_o && s_arvalid_i) begin
        s_rdata_o <= rd_mux;
        s_rresp_o <= rd_mapped ? OKAY : SLVERR;
        s_rvalid_o <= 1'b1;
        s_arready_o <= 1'b0;
        r_state <= R_DATA;
      end
    end else if (s_rready_i) begin
      s_rvalid_o <= 1'b0;
      s_arready_o <= 1'b1;
      r_state <= R_IDLE;
    end
  end
  // register file: DIN, start pulse, sticky status bits (set wins over clear), core result sample
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      din_o <= 32'd0;
      enable_in_o <= 1'b0;
      ack <= 1'b0;
      busyerr <= 1'b0;
      dout_q <= 32'd0;
    end else begin
      dout_q <= dout_i;
      enable_in_o <= start_evt;
      if (wr_commit && aw_idx == A_DIN) din_o <= din_next;
      ack <= enable_out_i[0] | (ack & !clr_ack);
      busyerr <= (start_evt && status_i != 2'd0) | (busyerr & !clr_be);
    end
  end
`ifdef CUSTOM_AXI_IP_IRQ_EN
  // interrupt enables and registered interrupt line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ier <= 2'b00;
      irq_o <= 1'b0;
    end else begin
      if (wr_commit && aw_idx == A_IER) ier <= wdata_q[1:0];
      irq_o <= |({busyerr, ack} & ier);
    end
  end
`endif
endmodule

// File: tb/tb_custom_axi_ip_axil_regs.sv
// tb_custom_axi_ip_axil_regs: randomized bench with a behavioural register-map model for custom_axi_ip_axil_regs
module tb_custom_axi_ip_axil_regs;
  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_DIN = 5'h04;
  localparam logic [4:0] A_DOUT = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;
  localparam logic [4:0] A_IER = 5'h10;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic [4:0] s_awaddr_i = '0, s_araddr_i = '0;
  logic s_awvalid_i = 0, s_wvalid_i = 0, s_bready_i = 0, s_arvalid_i = 0, s_rready_i = 0;
  logic [31:0] s_wdata_i = '0, dout_i = '0;
  logic [3:0] s_wstrb_i = '0;
  logic [1:0] enable_out_i = '0, status_i = '0;
  logic s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, enable_in_o;
  logic [1:0] s_bresp_o, s_rresp_o;
  logic [31:0] s_rdata_o, din_o;
`ifdef CUSTOM_AXI_IP_IRQ_EN
  logic irq_o;
`endif
  int n_chk = 0, n_fail = 0, pulse_cnt = 0;
  logic en_d = 1'b0;
  logic [31:0] m_din = '0;
  logic m_ack = 0, m_be = 0;
  logic [1:0] m_ier = '0;

  always #5 clk_i = ~clk_i;

  custom_axi_ip_axil_regs dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .din_o(din_o), .enable_in_o(enable_in_o), .dout_i(dout_i),
    .enable_out_i(enable_out_i), .status_i(status_i)
`ifdef CUSTOM_AXI_IP_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // core stand-in: counts start pulses and answers each with enable_out[0] one cycle later
  initial forever begin
    @(posedge clk_i);
    #1;
    if (enable_in_o) pulse_cnt++;
    enable_out_i = {1'b0, en_d};
    en_d = enable_in_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_mapped(input logic [4:0] a);
`ifdef CUSTOM_AXI_IP_IRQ_EN
    return a[4:2] <= 3'd4;
`else
    return a[4:2] <= 3'd3;
`endif
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    resp = m_mapped(a) ? 2'b00 : 2'b10;
    if (a == A_CTRL && d[0]) begin
      m_ack = 1'b1;
      if (status_i != 2'd0) m_be = 1'b1;
    end
    if (a == A_DIN) for (int i = 0; i < 4; i++) if (s[i]) m_din[8*i+:8] = d[8*i+:8];
    if (a == A_STAT) begin
      if (d[2]) m_ack = 1'b0;
      if (d[3]) m_be = 1'b0;
    end
    if (a == A_IER && m_mapped(a)) m_ier = d[1:0];
  endtask

  task automatic m_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = m_mapped(a) ? 2'b00 : 2'b10;
    d = 32'd0;
    if (a == A_DIN) d = m_din;
    if (a == A_DOUT) d = dout_i;
    if (a == A_STAT) d = {28'd0, m_be, m_ack, status_i};
    if (a == A_IER && m_mapped(a)) d = {30'd0, m_ier};
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int t;
    fork
      begin
        int ta = 0;
        repeat (aw_dly) @(posedge clk_i);
        #1 s_awaddr_i = addr; s_awvalid_i = 1'b1;
        @(negedge clk_i);
        while (!s_awready_o && ta < 50) begin ta++; @(negedge clk_i); end
        check("awready", 32'(s_awready_o), 32'd1);
        @(posedge clk_i);
        #1 s_awvalid_i = 1'b0;
      end
      begin
        int tw = 0;
        repeat (w_dly) @(posedge clk_i);
        #1 s_wdata_i = data; s_wstrb_i = strb; s_wvalid_i = 1'b1;
        @(negedge clk_i);
        while (!s_wready_o && tw < 50) begin tw++; @(negedge clk_i); end
        check("wready", 32'(s_wready_o), 32'd1);
        @(posedge clk_i);
        #1 s_wvalid_i = 1'b0;
      end
    join
    t = 0;
    @(negedge clk_i);
    while (!s_bvalid_o && t < 50) begin t++; @(negedge clk_i); end
    check("bvalid", 32'(s_bvalid_o), 32'd1);
    resp = s_bresp_o;
    for (int i = 0; i < b_dly; i++) begin
      check("bvalid_hold", 32'(s_bvalid_o), 32'd1);
      check("awready_in_resp", 32'(s_awready_o), 32'd0);
      check("wready_in_resp", 32'(s_wready_o), 32'd0);
      @(negedge clk_i);
    end
    s_bready_i = 1'b1;
    @(posedge clk_i);
    #1 s_bready_i = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    #1 s_araddr_i = addr; s_arvalid_i = 1'b1;
    @(negedge clk_i);
    while (!s_arready_o && t < 50) begin t++; @(negedge clk_i); end
    check("arready", 32'(s_arready_o), 32'd1);
    @(posedge clk_i);
    #1 s_arvalid_i = 1'b0;
    t = 0;
    @(negedge clk_i);
    while (!s_rvalid_o && t < 50) begin t++; @(negedge clk_i); end
    check("rvalid", 32'(s_rvalid_o), 32'd1);
    data = s_rdata_o;
    resp = s_rresp_o;
    s_rready_i = 1'b1;
    @(posedge clk_i);
    #1 s_rready_i = 1'b0;
  endtask

  task automatic wr_chk(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int awd, input int wd, input int bd);
    logic [1:0] r, er;
    axi_write(a, d, s, awd, wd, bd, r);
    m_write(a, d, s, er);
    check($sformatf("bresp@%02h", a), 32'(r), 32'(er));
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic rd_chk(input logic [4:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    axi_read(a, d, r);
    m_read(a, ed, er);
    check($sformatf("rdata@%02h", a), d, ed);
    check($sformatf("rresp@%02h", a), 32'(r), 32'(er));
  endtask

  task automatic model_reset();
    m_din = '0;
    m_ack = 1'b0;
    m_be = 1'b0;
    m_ier = '0;
  endtask

  initial begin
    int p0, t;
    logic [4:0] ra;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_awready", 32'(s_awready_o), 32'd0);
    check("rst_wready", 32'(s_wready_o), 32'd0);
    check("rst_arready", 32'(s_arready_o), 32'd0);
    check("rst_bvalid", 32'(s_bvalid_o), 32'd0);
    check("rst_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rst_bresp", 32'(s_bresp_o), 32'd0);
    check("rst_rresp", 32'(s_rresp_o), 32'd0);
    check("rst_rdata", s_rdata_o, 32'd0);
    check("rst_din", din_o, 32'd0);
    check("rst_enable_in", 32'(enable_in_o), 32'd0);
`ifdef CUSTOM_AXI_IP_IRQ_EN
    check("rst_irq", 32'(irq_o), 32'd0);
`endif
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    rd_chk(A_DIN);
    rd_chk(A_STAT);
    wr_chk(A_DIN, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("din_o_full", din_o, 32'hDEADBEEF);
    rd_chk(A_DIN);
    wr_chk(A_DIN, 32'h00005500, 4'h2, 0, 0, 0);
    check("din_o_strb", din_o, 32'hDEAD55EF);
    rd_chk(A_DIN);
    p0 = pulse_cnt;
    wr_chk(A_CTRL, 32'd1, 4'hF, 0, 0, 0);
    check("start_pulse", 32'(pulse_cnt - p0), 32'd1);
    rd_chk(A_STAT);
    rd_chk(A_CTRL);
    wr_chk(A_STAT, 32'h4, 4'hF, 0, 0, 0);
    rd_chk(A_STAT);
    p0 = pulse_cnt;
    wr_chk(A_CTRL, 32'd1, 4'hF, 2, 0, 0);
    check("pulse_aw_late", 32'(pulse_cnt - p0), 32'd1);
    p0 = pulse_cnt;
    wr_chk(A_CTRL, 32'd1, 4'hF, 0, 0, 5);
    check("pulse_b_stall", 32'(pulse_cnt - p0), 32'd1);
    wr_chk(A_DIN, 32'h12345678, 4'hF, 0, 2, 0);
    rd_chk(A_DIN);
    wr_chk(A_STAT, 32'hC, 4'hF, 0, 0, 0);
    rd_chk(A_STAT);
    rd_chk(5'h14);
    wr_chk(5'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    rd_chk(A_DIN);
    rd_chk(A_IER);
`ifdef CUSTOM_AXI_IP_IRQ_EN
    wr_chk(A_IER, 32'd1, 4'hF, 0, 0, 0);
    check("irq_idle", 32'(irq_o), 32'd0);
    wr_chk(A_CTRL, 32'd1, 4'hF, 0, 0, 0);
    check("irq_ack", 32'(irq_o), 32'd1);
    wr_chk(A_STAT, 32'h4, 4'hF, 0, 0, 0);
    check("irq_clr", 32'(irq_o), 32'd0);
    wr_chk(A_IER, 32'd0, 4'hF, 0, 0, 0);
`endif
    status_i = 2'd1;
    @(posedge clk_i);
    #1;
    p0 = pulse_cnt;
    wr_chk(A_CTRL, 32'd1, 4'hF, 0, 0, 0);
    check("pulse_busy", 32'(pulse_cnt - p0), 32'd1);
    rd_chk(A_STAT);
    wr_chk(A_STAT, 32'hC, 4'hF, 0, 0, 0);
    rd_chk(A_STAT);
    status_i = 2'd0;
    for (int n = 0; n < 80; n++) begin
      status_i = 2'($urandom_range(0, 3));
      dout_i = $urandom;
      @(posedge clk_i);
      #1;
      ra = {3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 1) == 0) begin
        p0 = pulse_cnt;
        wr_chk(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        if (ra == A_CTRL) check("rand_pulse", 32'(pulse_cnt - p0), 32'(m_ack ? (pulse_cnt - p0) : 0));
      end else rd_chk(ra);
`ifdef CUSTOM_AXI_IP_IRQ_EN
      check("rand_irq", 32'(irq_o), 32'(|({m_be, m_ack} & m_ier)));
`endif
    end
    status_i = 2'd0;
    wr_chk(A_DIN, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    #1 s_araddr_i = A_DIN; s_arvalid_i = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (!s_arready_o && t < 50) begin t++; @(negedge clk_i); end
    @(posedge clk_i);
    #1 s_arvalid_i = 1'b0;
    @(negedge clk_i);
    check("midread_rvalid", 32'(s_rvalid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("reset_drops_rvalid", 32'(s_rvalid_o), 32'd0);
    check("reset_din", din_o, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    rd_chk(A_DIN);
    rd_chk(A_STAT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
